spi_dac_rx: RTL and testbench

//  Synthesizable, parametrised SPI DAC-slave receiver; successor to the behavioural DAC model.

---
 rtl/spi_dac_rx.sv | 118 +++++++++++
 tb/tb_spi_dac_rx.sv | 130 +++++++++++++
 2 files changed

// File: rtl/spi_dac_rx.sv
// spi_dac_rx: SPI DAC-slave receiver, oversampled in the clk domain, routes frame data to channel registers
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   SCK, SDI, CS_               asynchronous SPI pins (CPOL=0, MSB first, active-low select)
//   ch_data                     NUM_CH packed channel registers, channel k at [k*DATA_W +: DATA_W]
//   upd_valid, upd_ch, upd_data 1-cycle write report for an accepted frame
//   len_err, addr_err           1-cycle pulses for rejected frames
// Build option: OFFSET_BINARY_EN stores/reports the word with its MSB inverted.
module spi_dac_rx #(
  parameter int DATA_W      = 16,
  parameter int CTRL_W      = 8,
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       SCK,
  input  logic                       SDI,
  input  logic                       CS_,
  output logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       upd_valid,
  output logic [3:0]                 upd_ch,
  output logic [DATA_W-1:0]          upd_data,
  output logic                       len_err,
  output logic                       addr_err
);
  localparam int FRAME_W = CTRL_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sck_s, r_sdi_s, r_cs_s;
  logic                   r_sck_d, r_sdi_d, r_cs_d;
  logic                   r_sck_rise, r_cs_rise, r_cs_fall;
  logic [FRAME_W-1:0]     r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   w_start, w_shift_en, w_check, w_len_ok, w_addr_ok, w_accept;
  logic [3:0]             w_addr;
  logic [DATA_W-1:0]      w_word;
  // Edge pulses are registered; r_sdi_d is the SDI sample taken alongside the SCK edge that r_sck_rise reports.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_s    <= '0;
      r_sdi_s    <= '0;
      r_cs_s     <= '1;
      r_sck_d    <= 1'b0;
      r_sdi_d    <= 1'b0;
      r_cs_d     <= 1'b1;
      r_sck_rise <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
    end else begin
      r_sck_s    <= {r_sck_s[SYNC_STAGES-2:0], SCK};
      r_sdi_s    <= {r_sdi_s[SYNC_STAGES-2:0], SDI};
      r_cs_s     <= {r_cs_s[SYNC_STAGES-2:0], CS_};
      r_sck_d    <= r_sck_s[SYNC_STAGES-1];
      r_sdi_d    <= r_sdi_s[SYNC_STAGES-1];
      r_cs_d     <= r_cs_s[SYNC_STAGES-1];
      r_sck_rise <= r_sck_s[SYNC_STAGES-1] & ~r_sck_d;
      r_cs_rise  <= r_cs_s[SYNC_STAGES-1] & ~r_cs_d;
      r_cs_fall  <= ~r_cs_s[SYNC_STAGES-1] & r_cs_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // A CS_ fall seen during CHECK starts the next frame directly.
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && r_cs_fall) w_next = SHIFT;
    else if (r_state == SHIFT && r_cs_rise) w_next = CHECK;
    else if (r_state == CHECK) w_next = r_cs_fall ? SHIFT : IDLE;
  end
  // cs_rise wins over a coincident SCK edge.
  always_comb begin
    w_start    = r_cs_fall && r_state != SHIFT;
    w_shift_en = r_state == SHIFT && r_sck_rise && !r_cs_rise;
    w_check    = r_state == CHECK;
  end
  assign w_addr    = r_shift[DATA_W +: 4];
  assign w_len_ok  = r_bit_cnt == CNT_W'(FRAME_W);
  assign w_addr_ok = int'(w_addr) < NUM_CH;
  assign w_accept  = w_check && w_len_ok && w_addr_ok;
`ifdef OFFSET_BINARY_EN
  assign w_word = {~r_shift[DATA_W-1], r_shift[DATA_W-2:0]};
`else
  assign w_word = r_shift[DATA_W-1:0];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      ch_data   <= '0;
      upd_valid <= 1'b0;
      upd_ch    <= '0;
      upd_data  <= '0;
      len_err   <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      upd_valid <= w_accept;
      len_err   <= w_check && !w_len_ok;
      addr_err  <= w_check && w_len_ok && !w_addr_ok;
      if (w_start) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_W-2:0], r_sdi_d};
        if (r_bit_cnt != CNT_W'(FRAME_W + 1)) r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_accept) begin
        upd_ch   <= w_addr;
        upd_data <= w_word;
        for (int k = 0; k < NUM_CH; k++)
          if (w_addr == 4'(k)) ch_data[k*DATA_W +: DATA_W] <= w_word;
      end
    end
  end
endmodule

// File: tb/tb_spi_dac_rx.sv
// tb_spi_dac_rx: randomized and directed frames against a frame-level reference model
module tb_spi_dac_rx;
  localparam int DW = 16, CW = 8, NCH = 2, SS = 2;
  logic clk = 0, reset = 1, SCK = 0, SDI = 0, CS_ = 1;
  logic [NCH*DW-1:0] ch_data;
  logic              upd_valid, len_err, addr_err;
  logic [3:0]        upd_ch;
  logic [DW-1:0]     upd_data;
  int                n_chk = 0, n_pass = 0, cyc = 0, cs_rise_cyc = 0, lat = -1;
  logic [21:0]       obs_q[$], exp_q[$];
  logic [DW-1:0]     m_ch[NCH];
  spi_dac_rx #(.DATA_W(DW), .CTRL_W(CW), .NUM_CH(NCH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .SCK(SCK), .SDI(SDI), .CS_(CS_),
    .ch_data(ch_data), .upd_valid(upd_valid), .upd_ch(upd_ch), .upd_data(upd_data),
    .len_err(len_err), .addr_err(addr_err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (upd_valid) begin
      obs_q.push_back({2'd0, upd_ch, upd_data});
      lat = cyc - cs_rise_cyc;
    end
    if (len_err) obs_q.push_back({2'd1, 20'd0});
    if (addr_err) obs_q.push_back({2'd2, 20'd0});
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [DW-1:0] conv(input logic [DW-1:0] d);
`ifdef OFFSET_BINARY_EN
    return {~d[DW-1], d[DW-2:0]};
`else
    return d;
`endif
  endfunction
  task automatic model(input logic [31:0] bits, input int n);
    logic [3:0] a;
    if (n != CW + DW) exp_q.push_back({2'd1, 20'd0});
    else begin
      a = bits[DW +: 4];
      if (a >= NCH) exp_q.push_back({2'd2, 20'd0});
      else begin
        m_ch[a] = conv(bits[DW-1:0]);
        exp_q.push_back({2'd0, a, conv(bits[DW-1:0])});
      end
    end
  endtask
  task automatic clks(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic send(input logic [31:0] bits, input int n, input int h, input int gap);
    model(bits, n);
    CS_ = 0;
    clks(h);
    for (int i = n - 1; i >= 0; i--) begin
      SDI = bits[i];
      clks(h);
      SCK = 1;
      clks(h);
      SCK = 0;
    end
    clks(h);
    CS_ = 1;
    cs_rise_cyc = cyc;
    clks(gap);
  endtask
  task automatic settle(input string tag);
    logic [NCH*DW-1:0] m;
    clks(20);
    chk({tag, "_nev"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) chk({tag, "_ev"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    for (int k = 0; k < NCH; k++) m[k*DW +: DW] = m_ch[k];
    chk({tag, "_ch"}, ch_data, m);
  endtask
  initial begin
    for (int k = 0; k < NCH; k++) m_ch[k] = '0;
    clks(4);
    chk("reset", {ch_data, upd_valid, upd_ch, upd_data, len_err, addr_err}, 64'd0);
    reset = 0;
    clks(4);
    send(32'h00_1234, 24, 4, 4);
    settle("f1234");
    chk("latency", lat, SS + 3);
    send(32'h01_ABCD, 24, 4, 4);
    send(32'h00_0001, 24, 4, 4);
    settle("two_ch");
    send(32'h00_7777, 23, 4, 4);
    send(32'h1_00_7777, 25, 4, 4);
    settle("len");
    send(32'h05_FFFF, 24, 4, 4);
    settle("addr");
    send(32'hF1_0042, 24, 4, 4);
    settle("upper_ctrl");
    CS_ = 0;
    clks(4);
    for (int i = 0; i < 12; i++) begin
      SDI = i[0];
      clks(4);
      SCK = 1;
      clks(4);
      SCK = 0;
    end
    reset = 1;
    CS_ = 1;
    clks(3);
    reset = 0;
    for (int k = 0; k < NCH; k++) m_ch[k] = '0;
    settle("abort");
    send(32'h00_5A5A, 24, 4, 4);
    settle("after_abort");
    send(32'h01_C3C3, 24, 2, 2);
    send(32'h00_8001, 24, 2, 2);
    settle("b2b");
    for (int r = 0; r < 20; r++) begin
      logic [31:0] bits;
      int n;
      bits = $urandom;
      bits[DW +: 4] = 4'($urandom_range(0, 3));
      n = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) != 0) ? 23 : 25) : 24;
      send(bits, n, $urandom_range(2, 4), $urandom_range(2, 6));
      settle("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
